// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : raster_pkg
//  Description : Shared widths, frame-sequencer state encoding and the packed
//                triangle-parameter record used by the geometry path.
//  Contents    : ANGLE_W / AX_W / AY_W / DELTA_W / DEPTH_W  field widths
//                ST_*                                       FSM state codes
//                tri_params                                 ax..cz record
//  Revision    : 1.0  initial release
// ============================================================================
package raster_pkg;

    localparam int ANGLE_W = 9;   // rotation angle, 0..359 fits in 9 bits
    localparam int AX_W    = 9;   // vertex A x coordinate
    localparam int AY_W    = 7;   // vertex A y coordinate
    localparam int DELTA_W = 8;   // edge deltas
    localparam int DEPTH_W = 7;   // vertex depths

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_ADVANCE   = 3'd1;
    localparam logic [STATE_W-1:0] ST_SETTLE    = 3'd2;
    localparam logic [STATE_W-1:0] ST_START     = 3'd3;
    localparam logic [STATE_W-1:0] ST_WAIT_DONE = 3'd4;
    localparam logic [STATE_W-1:0] ST_READY     = 3'd5;

    // Field order is the concatenation order {ax, ay, abx, aby, acx, acy, bz, cz}.
    typedef struct packed {
        logic        [AX_W-1:0]    ax;
        logic        [AY_W-1:0]    ay;
        logic signed [DELTA_W-1:0] abx;
        logic        [DELTA_W-1:0] aby;
        logic signed [DELTA_W-1:0] acx;
        logic        [DELTA_W-1:0] acy;
        logic        [DEPTH_W-1:0] bz;
        logic        [DEPTH_W-1:0] cz;
    } tri_params;

endpackage
`default_nettype wire

// File: rtl/angle_stepper.sv
`default_nettype none
// ============================================================================
//  Module      : angle_stepper
//  Description : Rotation angle register with modular increment, a frame
//                divider and a single-shot step latch used while paused.
//  Ports       : clk_pix   in   pixel clock
//                resetn    in   asynchronous active-low reset
//                advance   in   one-cycle strobe, once per frame
//                pause     in   level, freezes divider-driven advances
//                step      in   one-cycle pulse, one advance while paused
//                angle     out  current angle, 0..ANGLE_MAX-1
//  Revision    : 1.0  initial release
// ============================================================================
module angle_stepper
    import raster_pkg::*;
#(
    parameter int ANGLE_MAX  = 360,
    parameter int ANGLE_STEP = 1,
    parameter int FRAME_DIV  = 1
) (
    input  logic               clk_pix,
    input  logic               resetn,
    input  logic               advance,
    input  logic               pause,
    input  logic               step,
    output logic [ANGLE_W-1:0] angle
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(FRAME_DIV - 1);
    localparam logic [ANGLE_W:0]   STEP_EXT = (ANGLE_W + 1)'(ANGLE_STEP);
    localparam logic [ANGLE_W:0]   MAX_EXT  = (ANGLE_W + 1)'(ANGLE_MAX);

    logic [DIV_W-1:0]   div_cnt;
    logic               step_pending;
    logic               div_due;
    logic               do_step;
    logic [ANGLE_W:0]   angle_sum;
    logic [ANGLE_W-1:0] angle_next;

    // One extra bit on the sum so the wrap test cannot overflow.
    assign angle_sum  = {1'b0, angle} + STEP_EXT;
    assign angle_next = (angle_sum >= MAX_EXT) ? ANGLE_W'(angle_sum - MAX_EXT)
                                               : ANGLE_W'(angle_sum);

    assign div_due = (div_cnt == DIV_LAST);

    // While paused the divider keeps counting but only a latched step moves
    // the angle; a step and a due divider in the same frame give one advance.
    assign do_step = advance & (pause ? step_pending : div_due);

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            div_cnt      <= '0;
            step_pending <= 1'b0;
            angle        <= '0;
        end else begin
            if (advance) begin
                div_cnt <= div_due ? '0 : div_cnt + 1'b1;
            end
            if (do_step) begin
                angle <= angle_next;
            end
            // A fresh pulse wins over consumption so it is never dropped.
            if (pause && step) begin
                step_pending <= 1'b1;
            end else if (advance && pause && step_pending) begin
                step_pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_sequencer
//  Description : Per-frame geometry scheduler. Advances the rotation angle in
//                vertical blanking, runs one start/done transaction with the
//                vertex stage, captures its results into a shadow set and
//                publishes them to the rasterizer at frame start.
//  Ports       : clk_pix, resetn           clock, async active-low reset
//                vblank_start, frame_start timing pulses from the video timer
//                pause, step               angle freeze / single step
//                angle                     angle to the cos/bz/cz ROMs
//                vs_start, vs_done         vertex-stage handshake
//                in_ax .. in_cz            vertex-stage and ROM results
//                ax .. cz                  active set to the rasterizer
//                busy                      high outside IDLE
//                overrun                   sticky: frame started before done
//                frame_count               completed swaps, wraps at 16 bits
//  Revision    : 1.0  initial release
// ============================================================================
module frame_sequencer
    import raster_pkg::*;
#(
    parameter int ANGLE_MAX  = 360,
    parameter int ANGLE_STEP = 1,
    parameter int FRAME_DIV  = 1
) (
    input  logic                      clk_pix,
    input  logic                      resetn,
    input  logic                      vblank_start,
    input  logic                      frame_start,
    input  logic                      pause,
    input  logic                      step,
    output logic [ANGLE_W-1:0]        angle,
    output logic                      vs_start,
    input  logic                      vs_done,
    input  logic [AX_W-1:0]           in_ax,
    input  logic [AY_W-1:0]           in_ay,
    input  logic signed [DELTA_W-1:0] in_abx,
    input  logic [DELTA_W-1:0]        in_aby,
    input  logic signed [DELTA_W-1:0] in_acx,
    input  logic [DELTA_W-1:0]        in_acy,
    input  logic [DEPTH_W-1:0]        in_bz,
    input  logic [DEPTH_W-1:0]        in_cz,
    output logic [AX_W-1:0]           ax,
    output logic [AY_W-1:0]           ay,
    output logic signed [DELTA_W-1:0] abx,
    output logic [DELTA_W-1:0]        aby,
    output logic signed [DELTA_W-1:0] acx,
    output logic [DELTA_W-1:0]        acy,
    output logic [DEPTH_W-1:0]        bz,
    output logic [DEPTH_W-1:0]        cz,
    output logic                      busy,
    output logic                      overrun,
    output logic [15:0]               frame_count
);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;

    logic advance;
    logic capture;
    logic swap;
    logic overrun_set;

    tri_params shadow_set;
    tri_params active_set;
    tri_params in_set;

    assign in_set = '{ax: in_ax, ay: in_ay, abx: in_abx, aby: in_aby,
                      acx: in_acx, acy: in_acy, bz: in_bz, cz: in_cz};

    angle_stepper #(
        .ANGLE_MAX  (ANGLE_MAX),
        .ANGLE_STEP (ANGLE_STEP),
        .FRAME_DIV  (FRAME_DIV)
    ) u_angle_stepper (
        .clk_pix (clk_pix),
        .resetn  (resetn),
        .advance (advance),
        .pause   (pause),
        .step    (step),
        .angle   (angle)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (vblank_start) begin
                    state_next = ST_ADVANCE;
                end
            end
            ST_ADVANCE: state_next = ST_SETTLE;
            ST_SETTLE:  state_next = ST_START;
            ST_START:   state_next = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                // Completion wins a tie with frame_start; the swap then
                // slips to the following frame instead of flagging overrun.
                if (vs_done) begin
                    state_next = ST_READY;
                end else if (frame_start) begin
                    state_next = ST_IDLE;
                end
            end
            ST_READY: begin
                if (frame_start) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore outputs plus datapath strobes)
    // ------------------------------------------------------------------
    always_comb begin
        vs_start    = 1'b0;
        busy        = 1'b1;
        advance     = 1'b0;
        capture     = 1'b0;
        swap        = 1'b0;
        overrun_set = 1'b0;
        case (state)
            ST_IDLE:      busy     = 1'b0;
            ST_ADVANCE:   advance  = 1'b1;
            ST_START:     vs_start = 1'b1;
            ST_WAIT_DONE: begin
                capture     = vs_done;
                overrun_set = frame_start & ~vs_done;
            end
            ST_READY:     swap     = frame_start;
            default:      busy     = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow / active geometry and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            shadow_set  <= '0;
            active_set  <= '0;
            frame_count <= '0;
            overrun     <= 1'b0;
        end else begin
            if (capture) begin
                shadow_set <= in_set;
            end
            if (swap) begin
                active_set  <= shadow_set;
                frame_count <= frame_count + 16'd1;
            end
            if (overrun_set) begin
                overrun <= 1'b1;
            end
        end
    end

    assign ax  = active_set.ax;
    assign ay  = active_set.ay;
    assign abx = active_set.abx;
    assign aby = active_set.aby;
    assign acx = active_set.acx;
    assign acy = active_set.acy;
    assign bz  = active_set.bz;
    assign cz  = active_set.cz;

endmodule
`default_nettype wire

// File: tb/tb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_sequencer
//  Description : Self-checking bench. Three sequencers share one stimulus:
//                default, ANGLE_STEP=7, FRAME_DIV=3. A frame-level model
//                tracks the expected outputs and is compared every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_sequencer;
    import raster_pkg::*;

    logic clk_pix;
    logic resetn, vblank_start, frame_start, pause, step, vs_done;
    tri_params in_set;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [ANGLE_W-1:0] d_angle [3];
    logic               d_vss   [3];
    logic               d_busy  [3];
    logic               d_ovr   [3];
    logic [15:0]        d_fc    [3];
    tri_params          d_act   [3];

    // Frame-level model
    int        m_angle [3];
    int        m_nadv  [3];
    bit        m_pend  [3];
    tri_params m_shadow, m_active;
    int        m_fc;
    bit        m_ovr, m_busy, m_vss;

    initial begin
        clk_pix = 1'b0;
        forever #5 clk_pix = ~clk_pix;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [ANGLE_W-1:0]        angle;
        logic                      vs_s, bsy, ovr;
        logic [15:0]               fc;
        logic [AX_W-1:0]           ax;
        logic [AY_W-1:0]           ay;
        logic signed [DELTA_W-1:0] abx, acx;
        logic [DELTA_W-1:0]        aby, acy;
        logic [DEPTH_W-1:0]        bz, cz;

        frame_sequencer #(
            .ANGLE_MAX  (360),
            .ANGLE_STEP ((g == 1) ? 7 : 1),
            .FRAME_DIV  ((g == 2) ? 3 : 1)
        ) u_dut (
            .clk_pix      (clk_pix),
            .resetn       (resetn),
            .vblank_start (vblank_start),
            .frame_start  (frame_start),
            .pause        (pause),
            .step         (step),
            .angle        (angle),
            .vs_start     (vs_s),
            .vs_done      (vs_done),
            .in_ax        (in_set.ax),
            .in_ay        (in_set.ay),
            .in_abx       (in_set.abx),
            .in_aby       (in_set.aby),
            .in_acx       (in_set.acx),
            .in_acy       (in_set.acy),
            .in_bz        (in_set.bz),
            .in_cz        (in_set.cz),
            .ax           (ax),
            .ay           (ay),
            .abx          (abx),
            .aby          (aby),
            .acx          (acx),
            .acy          (acy),
            .bz           (bz),
            .cz           (cz),
            .busy         (bsy),
            .overrun      (ovr),
            .frame_count  (fc)
        );

        assign d_angle[g] = angle;
        assign d_vss[g]   = vs_s;
        assign d_busy[g]  = bsy;
        assign d_ovr[g]   = ovr;
        assign d_fc[g]    = fc;
        assign d_act[g]   = {ax, ay, abx, aby, acx, acy, bz, cz};
    end

    function automatic int step_of(int i);
        return (i == 1) ? 7 : 1;
    endfunction

    function automatic int div_of(int i);
        return (i == 2) ? 3 : 1;
    endfunction

    task automatic chk(string name, int i, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", name, i, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_angle[i] = 0;
            m_nadv[i]  = 0;
            m_pend[i]  = 1'b0;
        end
        m_shadow = '0;
        m_active = '0;
        m_fc     = 0;
        m_ovr    = 1'b0;
        m_busy   = 1'b0;
        m_vss    = 1'b0;
    endtask

    // The angle moves on every FRAME_DIV-th blanking interval since reset,
    // or, while paused, only when a step has been requested.
    task automatic model_advance();
        for (int i = 0; i < 3; i++) begin
            bit due;
            m_nadv[i]++;
            due = ((m_nadv[i] % div_of(i)) == 0);
            if (pause ? m_pend[i] : due) begin
                m_angle[i] = (m_angle[i] + step_of(i)) % 360;
            end
            if (pause) m_pend[i] = 1'b0;
        end
    endtask

    always @(negedge clk_pix) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk("angle",       i, 64'(d_angle[i]), 64'(m_angle[i]));
                chk("active_set",  i, 64'(d_act[i]),   64'(m_active));
                chk("frame_count", i, 64'(d_fc[i]),    64'(16'(m_fc)));
                chk("overrun",     i, 64'(d_ovr[i]),   64'(m_ovr));
                chk("busy",        i, 64'(d_busy[i]),  64'(m_busy));
                chk("vs_start",    i, 64'(d_vss[i]),   64'(m_vss));
            end
        end
    end

    // One frame: vblank, advance, settle, start, wait dly cycles (step pulses
    // in the first nsteps), then done + frame_start per the flags.
    task automatic do_frame(int dly, bit early_fs, bit same, int nsteps, bit pin1);
        logic [63:0] rnd;
        vblank_start = 1'b1; tick(); vblank_start = 1'b0; m_busy = 1'b1;
        tick(); model_advance();
        if (pin1) chk("first_angle", 0, 64'(d_angle[0]), 64'd1);
        tick(); m_vss = 1'b1;
        if (pin1) chk("first_vs_start", 0, 64'(d_vss[0]), 64'd1);
        tick(); m_vss = 1'b0;
        for (int k = 0; k < dly; k++) begin
            step = (k < nsteps);
            tick();
            if (step && pause) for (int i = 0; i < 3; i++) m_pend[i] = 1'b1;
        end
        step = 1'b0;
        if (early_fs) begin
            frame_start = 1'b1; tick(); frame_start = 1'b0;
            m_ovr = 1'b1; m_busy = 1'b0;
            tick();
            return;
        end
        rnd = {$urandom(), $urandom()};
        in_set = rnd[61:0];
        if (pin1) in_set.ax = 9'd100;
        vs_done = 1'b1; frame_start = same; tick();
        vs_done = 1'b0; frame_start = 1'b0; m_shadow = in_set;
        if (pin1) chk("first_ax_held", 0, 64'(d_act[0].ax), 64'd0);
        if (same) return;
        tick();
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        m_active = m_shadow; m_fc++; m_busy = 1'b0;
        if (pin1) begin
            chk("first_ax_swap", 0, 64'(d_act[0].ax), 64'd100);
            chk("first_fc",      0, 64'(d_fc[0]),     64'd1);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rnd;
        resetn = 1'b1; vblank_start = 1'b0; frame_start = 1'b0;
        pause = 1'b0; step = 1'b0; vs_done = 1'b0; in_set = '0;
        model_reset();
        #2 resetn = 1'b0;
        #1 chk_en = 1'b1;
        chk("rst_angle", 0, 64'(d_angle[0]), 64'd0);
        chk("rst_busy",  0, 64'(d_busy[0]),  64'd0);
        chk("rst_fc",    0, 64'(d_fc[0]),    64'd0);
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        // First frame with literal timing pins, then the long angle sweep.
        do_frame(10, 1'b0, 1'b0, 0, 1'b1);
        chk("div3_f1", 2, 64'(d_angle[2]), 64'd0);
        for (int f = 2; f <= 360; f++) begin
            do_frame(2, 1'b0, 1'b0, 0, 1'b0);
            if (f == 3)   chk("div3_f3",   2, 64'(d_angle[2]), 64'd1);
            if (f == 6)   chk("div3_f6",   2, 64'(d_angle[2]), 64'd2);
            if (f == 9)   chk("div3_f9",   2, 64'(d_angle[2]), 64'd3);
            if (f == 205) chk("step7_355", 1, 64'(d_angle[1]), 64'd355);
            if (f == 206) chk("step7_wrap",1, 64'(d_angle[1]), 64'd2);
            if (f == 359) chk("angle_359", 0, 64'(d_angle[0]), 64'd359);
            if (f == 360) chk("angle_wrap",0, 64'(d_angle[0]), 64'd0);
        end
        chk("fc_360", 0, 64'(d_fc[0]), 64'd360);

        // Pause holds the angle; two step pulses give exactly one advance.
        pause = 1'b1;
        repeat (5) do_frame(2, 1'b0, 1'b0, 0, 1'b0);
        chk("pause_hold", 0, 64'(d_angle[0]), 64'd0);
        do_frame(3, 1'b0, 1'b0, 2, 1'b0);
        chk("step_not_yet", 0, 64'(d_angle[0]), 64'd0);
        do_frame(2, 1'b0, 1'b0, 0, 1'b0);
        chk("step_once", 0, 64'(d_angle[0]), 64'd1);
        do_frame(2, 1'b0, 1'b0, 0, 1'b0);
        chk("step_consumed", 0, 64'(d_angle[0]), 64'd1);
        pause = 1'b0;

        // vs_done together with frame_start: capture now, swap one frame late.
        do_frame(2, 1'b0, 1'b1, 0, 1'b0);
        vblank_start = 1'b1; tick(); vblank_start = 1'b0;
        tick();
        chk("ready_ignores_vblank", 0, 64'(d_angle[0]), 64'd2);
        chk("ready_busy",           0, 64'(d_busy[0]),  64'd1);
        chk("same_no_overrun",      0, 64'(d_ovr[0]),   64'd0);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        m_active = m_shadow; m_fc++; m_busy = 1'b0;
        chk("late_swap_fc", 0, 64'(d_fc[0]), 64'd369);
        tick();

        // Overrun: frame_start before vs_done.
        do_frame(2, 1'b1, 1'b0, 0, 1'b0);
        chk("overrun_set", 0, 64'(d_ovr[0]),  64'd1);
        chk("overrun_fc",  0, 64'(d_fc[0]),   64'd369);
        chk("overrun_idle",0, 64'(d_busy[0]), 64'd0);
        do_frame(2, 1'b0, 1'b0, 0, 1'b0);
        chk("overrun_sticky", 0, 64'(d_ovr[0]), 64'd1);
        chk("after_overrun_fc", 0, 64'(d_fc[0]), 64'd370);

        // Reset in WAIT_DONE, then a stray vs_done after release.
        vblank_start = 1'b1; tick(); vblank_start = 1'b0; m_busy = 1'b1;
        tick(); model_advance();
        tick(); m_vss = 1'b1;
        tick(); m_vss = 1'b0;
        tick();
        #2 resetn = 1'b0;
        #1 model_reset();
        chk("arst_busy",    0, 64'(d_busy[0]),  64'd0);
        chk("arst_vs",      0, 64'(d_vss[0]),   64'd0);
        chk("arst_angle",   0, 64'(d_angle[0]), 64'd0);
        chk("arst_active",  0, 64'(d_act[0]),   64'd0);
        chk("arst_overrun", 0, 64'(d_ovr[0]),   64'd0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        rnd = {$urandom(), $urandom()};
        in_set = rnd[61:0];
        vs_done = 1'b1; tick(); vs_done = 1'b0;
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick();
        chk("late_done_active", 0, 64'(d_act[0]), 64'd0);
        chk("late_done_fc",     0, 64'(d_fc[0]),  64'd0);
        do_frame(2, 1'b0, 1'b0, 0, 1'b0);
        chk("post_rst_fc",    0, 64'(d_fc[0]),    64'd1);
        chk("post_rst_angle", 0, 64'(d_angle[0]), 64'd1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
